// File: rtl/hex_seq_pkg.sv
// Shared types and constants for the hex display sequencer.
package hex_seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low seven-segment patterns, bit0=a .. bit6=g; entry 0 is the LSB element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_seg_encode.sv
// Nibble to active-low seven-segment pattern, with forced blank.
module hex_seg_encode
  import hex_seq_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup, overridden by blanking.
  always_comb begin
    seg = SEG_TABLE[nibble];
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Avalon-MM master writing one segment pattern per digit to a bank of hex PIOs.
module hex_display_sequencer
  import hex_seq_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] DIGIT_STRIDE = 32'h0000_0010
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    value_valid,
  input  logic [4*NUM_DIGITS-1:0] value_data,
  input  logic                    value_blank_lz,
  output logic                    value_ready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  input  logic                    avm_waitrequest
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [31:0]             addr_q, addr_d;
  logic [6:0]              seg_q, seg_d;
  logic                    write_q, write_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic [NUM_DIGITS-1:0]   mask_calc;
  logic                    above_zero;
  logic [IDX_W-1:0]        idx_nxt;
  logic [3:0]              enc_nibble;
  logic                    enc_blank;
  logic [6:0]              enc_seg;

  // Blank mask from the incoming value: digit i blanks when it and all higher nibbles are zero.
  always_comb begin
    mask_calc  = '0;
    above_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      above_zero = above_zero && (value_data[(NUM_DIGITS-1-k)*4 +: 4] == 4'h0);
      if (k != NUM_DIGITS - 1) begin
        mask_calc[NUM_DIGITS-1-k] = value_blank_lz && above_zero;
      end
    end
  end

  // Encoder source is the digit the next write will carry: digit 0 of the
  // incoming value when idle, otherwise digit idx+1 of the latched value.
  always_comb begin
    idx_nxt    = idx_q + IDX_W'(1);
    enc_nibble = value_data[3:0];
    enc_blank  = 1'b0;
    if (state_q == S_WRITE) begin
      enc_nibble = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_nxt == IDX_W'(i)) begin
          enc_nibble = value_q[i*4 +: 4];
          enc_blank  = mask_q[i];
        end
      end
    end
  end

  hex_seg_encode u_seg_encode (
    .nibble (enc_nibble),
    .blank  (enc_blank),
    .seg    (enc_seg)
  );

  // Next-state logic: accept in IDLE, advance one digit per completed write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    seg_d   = seg_q;
    write_d = write_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (value_valid && ready_q) begin
          value_d = value_data;
          mask_d  = mask_calc;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          seg_d   = enc_seg;
          write_d = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (write_q && !avm_waitrequest) begin
          if (idx_q == IDX_LAST) begin
            write_d = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_nxt;
            addr_d = addr_q + DIGIT_STRIDE;
            seg_d  = enc_seg;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      value_q <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      seg_q   <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      seg_q   <= seg_d;
      write_q <= write_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign value_ready   = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_writedata = {25'b0, seg_q};

endmodule
